// File: rtl/add16_seq_ctrl.sv
// Sequential nibble-serial adder with a valid/ready front end and back end.
// One 4-bit ripple slice is evaluated per cycle, so a NIBBLES-slice add takes
// NIBBLES cycles in ADD, then the result is held in DONE until it is taken.
//
// Handshake rules (both ports): a transfer happens on a rising clk edge where
// valid and ready are both high. The producer holds valid and its data stable
// until that edge; ready may be driven high or low independently of valid.
// Here in_ready is high only in IDLE, and out_valid is high only in DONE.
module add16_seq_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  input  logic                 cin,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*NIBBLES-1:0] sum,
  output logic                 cout,
  output logic                 ovf,
  output logic                 busy
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state;
  logic [IW-1:0] idx;
  logic          carry;
  logic [W-1:0]  a_r;
  logic [W-1:0]  b_r;

  logic [3:0]    a_nib;
  logic [3:0]    b_nib;
  logic [4:0]    slice;
  logic          top_cin;

  // Select the current operand nibbles and form the 4-bit ripple slice.
  always_comb begin
    a_nib = '0;
    b_nib = '0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (idx == IW'(i)) begin
        a_nib = a_r[i*4 +: 4];
        b_nib = b_r[i*4 +: 4];
      end
    end
    slice   = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0000, carry};
    // Carry into bit 3 of the slice recovered from the sum bit.
    top_cin = a_nib[3] ^ b_nib[3] ^ slice[3];
  end

  // Controller FSM with registered handshake, status and result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      idx       <= '0;
      carry     <= 1'b0;
      a_r       <= '0;
      b_r       <= '0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          // in_ready is always high here, so in_valid alone marks an accept.
          // sum/cout/ovf keep the previous result until overwritten.
          if (in_valid) begin
            a_r      <= a;
            b_r      <= b;
            carry    <= cin;
            idx      <= '0;
            state    <= S_ADD;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        S_ADD: begin
          for (int i = 0; i < NIBBLES; i++) begin
            if (idx == IW'(i)) sum[i*4 +: 4] <= slice[3:0];
          end
          carry <= slice[4];
          if (idx == IW'(NIBBLES - 1)) begin
            idx       <= '0;
            cout      <= slice[4];
            ovf       <= top_cin ^ slice[4];
            out_valid <= 1'b1;
            state     <= S_DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        S_DONE: begin
          // Result handshake; in_ready returns one cycle later, so no
          // accept can coincide with this edge.
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          busy      <= 1'b0;
          in_ready  <= 1'b1;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule
